// File: rtl/seq_s_pg_rca16.sv
// Serial signed N-bit adder/subtractor: one 16-bit propagate/generate ripple slice per cycle.
// The result is sign-extended to N+1 bits, and a signed-overflow flag is produced at completion.
module seq_s_pg_rca16 #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS:0]     out,
    output logic                  ovf
);

    localparam int unsigned N  = 16 * WORDS;
    localparam int unsigned SW = 16;
    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          carry_q;
    logic [KW-1:0] k_q;

    logic [KW+3:0] idx;
    logic          last;
    logic [SW-1:0] as;
    logic [SW-1:0] bs;
    logic [SW-1:0] p;
    logic [SW-1:0] g;
    logic [SW-1:0] s;
    logic [SW:0]   c;
    logic          ext;

    assign idx  = {k_q, 4'b0000};
    assign last = (k_q == KW'(WORDS - 1));
    assign as   = a_q[idx +: SW];
    assign bs   = b_q[idx +: SW];

    // Single 16-bit propagate/generate ripple slice, fed from the latched operands.
    always_comb begin
        p    = as ^ bs;
        g    = as & bs;
        c    = '0;
        s    = '0;
        c[0] = carry_q;
        for (int i = 0; i < int'(SW); i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            s[i]   = p[i] ^ c[i];
        end
        ext = as[SW-1] ^ bs[SW-1] ^ c[SW];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, operand latches, slice writes; busy/done track the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= '0;
            ovf     <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        k_q     <= '0;
                        ovf     <= 1'b0;
                    end
                end
                RUN: begin
                    out[idx +: SW] <= s;
                    carry_q        <= c[SW];
                    if (last) begin
                        out[N] <= ext;
                        ovf    <= ext ^ s[SW-1];
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_s_pg_rca16.sv
// Directed self-checking bench for seq_s_pg_rca16 with WORDS=4.
module tb_seq_s_pg_rca16;

    localparam int unsigned WORDS = 4;
    localparam int unsigned N     = 16 * WORDS;
    localparam int          LAT   = WORDS + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N:0]   out;
    logic         ovf;

    int vectors;
    int miscompares;

    typedef struct {
        logic [N-1:0] va;
        logic [N-1:0] vb;
        logic         vsub;
        logic [N:0]   eout;
        logic         eovf;
    } vec_t;

    vec_t vecs[8];

    seq_s_pg_rca16 #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation from IDLE and wait (bounded) for its done pulse.
    task automatic do_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic isub,
                         output logic [N:0] r, output logic ro, output int lat);
        @(negedge clk);
        a = ia; b = ib; sub = isub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r  = out;
        ro = ovf;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; sub = 1'b0; a = 64'h1; b = 64'h1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 65'h0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b out=%h ovf=%b, required 0/0/0/0", busy, done, out, ovf);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_accept: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_arith;
        logic [N:0] r;
        logic       ro;
        int         lat;
        vecs[0] = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65'h0_0000_0000_0000_0000, 1'b0};
        vecs[1] = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 65'h0_0000_0000_0001_0000, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 65'h0_8000_0000_0000_0000, 1'b1};
        vecs[3] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 65'h1_7FFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 65'h0_2345_6789_ABCD_F001, 1'b0};
        vecs[6] = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 65'h1_0000_0000_0000_0000, 1'b1};
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, r, ro, lat);
            vectors++;
            if (lat !== LAT) begin
                miscompares++;
                $display("FAIL arith_latency[%0d]: got %0d cycles, required %0d", i, lat, LAT);
            end
            vectors++;
            if (r !== vecs[i].eout || ro !== vecs[i].eovf) begin
                miscompares++;
                $display("FAIL arith_result[%0d]: out=%h ovf=%b, required out=%h ovf=%b",
                         i, r, ro, vecs[i].eout, vecs[i].eovf);
            end
        end
    endtask

    task automatic test_busy_timing;
        logic [6:0] bseen;
        logic [6:0] dseen;
        logic       oseen;
        @(negedge clk);
        a = 64'h0; b = 64'h0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bseen = '0; dseen = '0; oseen = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bseen[i] = busy;
            dseen[i] = done;
            if (dseen[i] !== 1'b1 && ovf !== 1'b0) oseen = 1'b1;
            if (i < 6) @(negedge clk);
        end
        vectors++;
        if (bseen[6:1] !== 6'b011111) begin
            miscompares++;
            $display("FAIL busy_window: busy cycles t+6..t+1=%b, required 011111", bseen[6:1]);
        end
        vectors++;
        if (dseen[6:1] !== 6'b010000) begin
            miscompares++;
            $display("FAIL done_pulse: done cycles t+6..t+1=%b, required 010000", dseen[6:1]);
        end
        vectors++;
        if (oseen !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_during_run: ovf was %b while running, required 0", oseen);
        end
    endtask

    task automatic test_ignore_start;
        int         lat;
        logic [N:0] held;
        @(negedge clk);
        a = 64'h1; b = 64'h1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        @(negedge clk);
        lat++;
        a = 64'h100; b = 64'h100; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== LAT || out !== 65'h2 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start_result: lat=%0d out=%h ovf=%b, required lat=%0d out=2 ovf=0", lat, out, ovf, LAT);
        end
        held = out;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || out !== 65'h2) begin
                miscompares++;
                $display("FAIL ignore_start_idle: busy=%b out=%h, required busy=0 out=2 (prev %h)", busy, out, held);
            end
        end
    endtask

    task automatic test_back_to_back;
        int d_first;
        int d_second;
        int d_count;
        logic [N:0] r1;
        logic [N:0] r2;
        d_first = -1; d_second = -1; d_count = 0;
        r1 = '0; r2 = '0;
        @(negedge clk);
        a = 64'h10; b = 64'h20; sub = 1'b0; start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a = 64'h1000; b = 64'h0001; sub = 1'b1;
            end
            if (i == 12) start = 1'b0;
            if (done === 1'b1) begin
                d_count++;
                if (d_first < 0) begin
                    d_first = i; r1 = out;
                end else begin
                    d_second = i; r2 = out;
                end
            end
        end
        vectors++;
        if (d_count !== 2 || d_first !== LAT || d_second - d_first !== WORDS + 2) begin
            miscompares++;
            $display("FAIL b2b_spacing: pulses=%0d at %0d,%0d, required 2 at %0d,%0d",
                     d_count, d_first, d_second, LAT, LAT + WORDS + 2);
        end
        vectors++;
        if (r1 !== 65'h30 || r2 !== 65'h0FFF) begin
            miscompares++;
            $display("FAIL b2b_results: %h,%h, required 30,fff", r1, r2);
        end
    endtask

    task automatic test_reset_abort;
        int         dcount;
        logic [N:0] r;
        logic       ro;
        int         lat;
        @(negedge clk);
        a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'h1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 65'h0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: busy=%b done=%b out=%h ovf=%b, required 0/0/0/0", busy, done, out, ovf);
        end
        dcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dcount++;
        end
        vectors++;
        if (dcount !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: %0d busy/done cycles after abort, required 0", dcount);
        end
        do_op(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, r, ro, lat);
        vectors++;
        if (lat !== LAT || r !== 65'h0_0000_0001_0000_0000 || ro !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_recover: lat=%0d out=%h ovf=%b, required lat=%0d out=100000000 ovf=0", lat, r, ro, LAT);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        test_reset();
        test_arith();
        test_busy_timing();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
